// File: rtl/frame_stream_decoder_if.sv
// Handshake bundle between the frame queue FIFO, the decoder and the pixel sink.
// The decoder uses the slave view; the queue/sink environment uses the master view.
interface frame_stream_decoder_if;
  logic        queue_empty;
  logic [16:0] queue_data;
  logic        queue_rd_en;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_sof;
  logic        pix_sol;
  logic        pix_eol;
  logic        pix_eof;
  logic        frame_done;
  logic        proto_error;
  logic [2:0]  err_code;

  modport master (
    output queue_empty, queue_data, pix_ready,
    input  queue_rd_en, pix_data, pix_valid, pix_sof, pix_sol, pix_eol, pix_eof,
           frame_done, proto_error, err_code
  );

  modport slave (
    input  queue_empty, queue_data, pix_ready,
    output queue_rd_en, pix_data, pix_valid, pix_sof, pix_sol, pix_eol, pix_eof,
           frame_done, proto_error, err_code
  );
endinterface

// File: rtl/frame_stream_decoder.sv
// Pops 17-bit words from the frame queue, parses SOF/SOL/EOF control words and
// emits RGB565 pixels with frame/row markers, flagging geometry errors.
module frame_stream_decoder #(
  parameter int FRAME_WIDTH  = 480,
  parameter int FRAME_HEIGHT = 272
) (
  input logic                  clk,
  input logic                  reset,
  frame_stream_decoder_if.slave bus
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_ROW = 2'd1;
  localparam logic [1:0] ROW      = 2'd2;

  localparam logic [16:0] W_SOF = 17'h10000;
  localparam logic [16:0] W_SOL = 17'h10001;
  localparam logic [16:0] W_EOF = 17'h1FFFF;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_SHORT   = 3'd1;
  localparam logic [2:0] ERR_LONG    = 3'd2;
  localparam logic [2:0] ERR_ROWS    = 3'd3;
  localparam logic [2:0] ERR_SOF     = 3'd4;
  localparam logic [2:0] ERR_STRAY   = 3'd5;
  localparam logic [2:0] ERR_UNKNOWN = 3'd6;

  localparam logic [10:0] WIDTH_C  = 11'(FRAME_WIDTH);
  localparam logic [10:0] HEIGHT_C = 11'(FRAME_HEIGHT);

  // Two-entry input buffer plus one outstanding FIFO read
  logic [16:0] buf_q [2];
  logic        wr_ptr_q, rd_ptr_q, inflight_q;
  logic [1:0]  count_q, count_d;

  logic [1:0]  state_q, state_d;
  logic [10:0] col_q, col_d, row_q, row_d;
  logic        long_q, long_d;

  logic        pop, load, done_d;
  logic [2:0]  err_d;

  logic [15:0] pix_data_q;
  logic        pix_valid_q, sof_q, sol_q, eol_q, eof_q;
  logic        frame_done_q, proto_error_q;
  logic [2:0]  err_code_q;

  logic [16:0] head;
  logic        head_valid, head_ctrl, head_known, out_free;
  logic [2:0]  occ_after;
  logic [10:0] col_inc, row_inc;

  assign head       = buf_q[rd_ptr_q];
  assign head_valid = (count_q != 2'd0);
  assign head_ctrl  = head[16];
  assign head_known = (head == W_SOF) || (head == W_SOL) || (head == W_EOF);
  assign out_free   = !pix_valid_q || bus.pix_ready;
  assign col_inc    = col_q + 11'd1;
  assign row_inc    = row_q + 11'd1;

  // Room left after this cycle's capture and pop decides whether to request more
  assign occ_after       = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign bus.queue_rd_en = !reset && !bus.queue_empty && (occ_after < 3'd2);
  assign count_d         = count_q + {1'b0, inflight_q} - {1'b0, pop};

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    long_d  = long_q;
    pop     = 1'b0;
    load    = 1'b0;
    err_d   = ERR_NONE;
    done_d  = 1'b0;

    if (head_valid) begin
      if (head_ctrl && !head_known) begin
        pop    = 1'b1;
        err_d  = ERR_UNKNOWN;
        long_d = 1'b0;
      end else if (head == W_SOF) begin
        pop     = 1'b1;
        row_d   = '0;
        col_d   = '0;
        long_d  = 1'b0;
        state_d = WAIT_ROW;
        if (state_q != IDLE) err_d = ERR_SOF;
      end else begin
        case (state_q)
          WAIT_ROW: begin
            pop = 1'b1;
            if (head == W_SOL) begin
              long_d = 1'b0;
              if (row_q < HEIGHT_C) begin
                col_d   = '0;
                state_d = ROW;
              end else begin
                err_d = ERR_ROWS;
              end
            end else if (head == W_EOF) begin
              long_d  = 1'b0;
              state_d = IDLE;
              if (row_q == HEIGHT_C) done_d = 1'b1;
              else                   err_d  = ERR_ROWS;
            end else begin
              err_d = long_q ? ERR_LONG : ERR_STRAY;
            end
          end
          ROW: begin
            if (!head_ctrl) begin
              if (out_free) begin
                pop   = 1'b1;
                load  = 1'b1;
                col_d = col_inc;
                if (col_inc == WIDTH_C) begin
                  row_d   = row_inc;
                  long_d  = 1'b1;
                  state_d = WAIT_ROW;
                end
              end
            end else if (head == W_SOL) begin
              // Short row closes, and the SOL then opens the next row if one is allowed
              pop   = 1'b1;
              err_d = ERR_SHORT;
              row_d = row_inc;
              if (row_inc < HEIGHT_C) col_d = '0;
              else                    state_d = WAIT_ROW;
            end else begin
              pop     = 1'b1;
              err_d   = ERR_SHORT;
              row_d   = row_inc;
              state_d = IDLE;
            end
          end
          default: begin
            pop   = 1'b1;
            err_d = ERR_STRAY;
          end
        endcase
      end
    end
  end

  // NOTE: buffer storage is data only; occupancy is tracked by reset pointers, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (inflight_q) buf_q[wr_ptr_q] <= bus.queue_data;
  end

  // NOTE: state registers use non-blocking assignments so every block sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      inflight_q    <= 1'b0;
      count_q       <= 2'd0;
      state_q       <= IDLE;
      col_q         <= '0;
      row_q         <= '0;
      long_q        <= 1'b0;
      pix_data_q    <= '0;
      pix_valid_q   <= 1'b0;
      sof_q         <= 1'b0;
      sol_q         <= 1'b0;
      eol_q         <= 1'b0;
      eof_q         <= 1'b0;
      frame_done_q  <= 1'b0;
      proto_error_q <= 1'b0;
      err_code_q    <= ERR_NONE;
    end else begin
      inflight_q <= bus.queue_rd_en;
      if (inflight_q) wr_ptr_q <= !wr_ptr_q;
      if (pop)        rd_ptr_q <= !rd_ptr_q;
      count_q <= count_d;
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      long_q  <= long_d;

      if (load) begin
        pix_valid_q <= 1'b1;
        pix_data_q  <= head[15:0];
        sof_q       <= (row_q == 11'd0) && (col_q == 11'd0);
        sol_q       <= (col_q == 11'd0);
        eol_q       <= (col_inc == WIDTH_C);
        eof_q       <= (col_inc == WIDTH_C) && (row_inc == HEIGHT_C);
      end else if (bus.pix_ready) begin
        pix_valid_q <= 1'b0;
      end

      frame_done_q  <= done_d;
      proto_error_q <= (err_d != ERR_NONE);
      if (err_d != ERR_NONE) err_code_q <= err_d;
    end
  end

  assign bus.pix_data    = pix_data_q;
  assign bus.pix_valid   = pix_valid_q;
  assign bus.pix_sof     = sof_q;
  assign bus.pix_sol     = sol_q;
  assign bus.pix_eol     = eol_q;
  assign bus.pix_eof     = eof_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.proto_error = proto_error_q;
  assign bus.err_code    = err_code_q;
endmodule

// File: tb/tb_frame_stream_decoder.sv
// Scoreboard bench for frame_stream_decoder with a 4x2 frame geometry.
module tb_frame_stream_decoder;
  localparam int W = 4;
  localparam int H = 2;

  localparam logic [16:0] SOF = 17'h10000;
  localparam logic [16:0] SOL = 17'h10001;
  localparam logic [16:0] EOF = 17'h1FFFF;

  logic clk = 1'b0;
  logic reset;

  frame_stream_decoder_if bus();

  frame_stream_decoder #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  logic [16:0] fifo_q [$];
  logic [19:0] exp_q  [$];   // {sof, sol, eol, eof, data}

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 0;        // 0: always ready, 1: toggling, 2: never ready
  int done_cnt, perr_cnt, acc_n, acc_first, acc_last, rd_block_cnt;
  logic [2:0] last_err;

  // FIFO model: a pop on rd_en presents its word during the following cycle
  initial begin
    logic [16:0] w;
    logic        popped;
    bus.queue_empty = 1'b1;
    bus.queue_data  = 17'h15A5A;
    bus.pix_ready   = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      popped = 1'b0;
      w      = 17'h15A5A;
      if (bus.queue_rd_en && fifo_q.size() > 0) begin
        w      = fifo_q.pop_front();
        popped = 1'b1;
      end
      #1;
      bus.queue_data  = popped ? w : 17'h15A5A;
      bus.queue_empty = (fifo_q.size() == 0);
      case (ready_mode)
        0:       bus.pix_ready = 1'b1;
        1:       bus.pix_ready = ~bus.pix_ready;
        default: bus.pix_ready = 1'b0;
      endcase
    end
  end

  // Output monitor: scoreboard compare, stall hold check, event counters
  initial begin
    logic [20:0] held;
    logic [20:0] now;
    logic [19:0] e;
    logic        stall_prev;
    stall_prev = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      now = {bus.pix_valid, bus.pix_sof, bus.pix_sol, bus.pix_eol, bus.pix_eof, bus.pix_data};
      if (reset) begin
        stall_prev = 1'b0;
      end else begin
        if (bus.frame_done) done_cnt++;
        if (bus.proto_error) begin
          perr_cnt++;
          last_err = bus.err_code;
        end
        if (!bus.queue_empty && !bus.queue_rd_en) rd_block_cnt++;
        if (stall_prev) begin
          checks++;
          if (now !== held) begin
            errors++;
            $display("FAIL hold: got %h expected %h", now, held);
          end
        end
        if (bus.pix_valid && bus.pix_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pixel: got %h expected none", now[19:0]);
          end else begin
            e = exp_q.pop_front();
            if (now[19:0] !== e) begin
              errors++;
              $display("FAIL pixel: got %h expected %h", now[19:0], e);
            end
          end
          if (acc_n == 0) acc_first = cyc;
          acc_last = cyc;
          acc_n++;
        end
        stall_prev = bus.pix_valid && !bus.pix_ready;
        held       = now;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic start_test();
    done_cnt     = 0;
    perr_cnt     = 0;
    acc_n        = 0;
    acc_first    = 0;
    acc_last     = 0;
    rd_block_cnt = 0;
    last_err     = 3'd0;
  endtask

  task automatic put_px(input int row, input int col, input logic [15:0] v);
    fifo_q.push_back({1'b0, v});
    exp_q.push_back({(row == 0) && (col == 0), col == 0, col == W - 1,
                     (col == W - 1) && (row == H - 1), v});
  endtask

  task automatic put_row(input int row, input int n, input logic [15:0] first);
    fifo_q.push_back(SOL);
    for (int c = 0; c < n; c++) put_px(row, c, first + 16'(c));
  endtask

  task automatic put_frame(input logic [15:0] first);
    fifo_q.push_back(SOF);
    put_row(0, W, first);
    put_row(1, W, first + 16'(W));
    fifo_q.push_back(EOF);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || !bus.queue_empty) && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    checks++;
    if (fifo_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pixels pending expected 0", name, exp_q.size());
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    ready_mode = 0;
    reset = 1'b1;
    fifo_q.push_back(17'h00042);
    repeat (3) @(posedge clk);
    #2;
    if (bus.queue_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", bus.queue_rd_en); end
    if (bus.pix_valid !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.pix_valid); end
    if (bus.pix_data !== 16'h0)   begin errors++; $display("FAIL reset_data: got %h expected 0", bus.pix_data); end
    if ({bus.pix_sof, bus.pix_sol, bus.pix_eol, bus.pix_eof} !== 4'b0) begin
      errors++; $display("FAIL reset_markers: got %b expected 0000", {bus.pix_sof, bus.pix_sol, bus.pix_eol, bus.pix_eof});
    end
    if ({bus.frame_done, bus.proto_error} !== 2'b0) begin
      errors++; $display("FAIL reset_pulses: got %b expected 00", {bus.frame_done, bus.proto_error});
    end
    if (bus.err_code !== 3'd0)    begin errors++; $display("FAIL reset_err_code: got %0d expected 0", bus.err_code); end
    checks += 6;
    fifo_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.pix_valid !== 1'b0 || bus.err_code !== 3'd0) begin
      errors++; $display("FAIL post_reset_idle: got valid %b err %0d expected 0 0", bus.pix_valid, bus.err_code);
    end
  endtask

  task automatic test_full_frame();
    start_test();
    ready_mode = 0;
    put_frame(16'h0001);
    wait_drain("full_frame", 200);
    check_int("full_frame_pixels", acc_n, 8);
    // Two rows of four back-to-back pixels with one idle cycle for the second SOL
    check_int("full_frame_span", acc_last - acc_first, 8);
    check_int("full_frame_done", done_cnt, 1);
    check_int("full_frame_errors", perr_cnt, 0);
  endtask

  task automatic test_back_to_back_stall();
    start_test();
    ready_mode = 1;
    put_frame(16'h0001);
    wait_drain("stall", 400);
    check_int("stall_pixels", acc_n, 8);
    check_int("stall_done", done_cnt, 1);
    check_int("stall_errors", perr_cnt, 0);
    checks++;
    if (rd_block_cnt == 0) begin
      errors++; $display("FAIL stall_rd_throttle: got %0d blocked cycles expected >0", rd_block_cnt);
    end
    ready_mode = 0;
  endtask

  task automatic test_short_row();
    start_test();
    fifo_q.push_back(SOF);
    put_row(0, 3, 16'h0001);
    put_row(1, W, 16'h0011);
    fifo_q.push_back(EOF);
    wait_drain("short_row", 200);
    check_int("short_row_pixels", acc_n, 7);
    check_int("short_row_errors", perr_cnt, 1);
    check_int("short_row_code", last_err, 1);
    check_int("short_row_held_code", bus.err_code, 1);
    check_int("short_row_done", done_cnt, 1);
  endtask

  task automatic test_mid_sof();
    start_test();
    fifo_q.push_back(SOF);
    put_row(0, 2, 16'h0021);
    put_frame(16'h0031);
    wait_drain("mid_sof", 200);
    check_int("mid_sof_pixels", acc_n, 10);
    check_int("mid_sof_errors", perr_cnt, 1);
    check_int("mid_sof_code", last_err, 4);
    check_int("mid_sof_done", done_cnt, 1);
  endtask

  task automatic test_unknown_ctrl();
    start_test();
    fifo_q.push_back(SOF);
    fifo_q.push_back(SOL);
    put_px(0, 0, 16'h0041);
    put_px(0, 1, 16'h0042);
    fifo_q.push_back(17'h12345);
    put_px(0, 2, 16'h0043);
    put_px(0, 3, 16'h0044);
    put_row(1, W, 16'h0045);
    fifo_q.push_back(EOF);
    wait_drain("unknown", 200);
    check_int("unknown_pixels", acc_n, 8);
    check_int("unknown_errors", perr_cnt, 1);
    check_int("unknown_code", last_err, 6);
    check_int("unknown_done", done_cnt, 1);
  endtask

  task automatic test_reset_midstream();
    int n = 0;
    start_test();
    ready_mode = 0;
    put_frame(16'h0051);
    while (!bus.pix_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.pix_valid) begin
      errors++; $display("FAIL midreset_wait: got valid 0 expected 1");
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.pix_valid, bus.queue_rd_en, bus.pix_sof, bus.pix_sol, bus.pix_eol, bus.pix_eof,
         bus.frame_done, bus.proto_error} !== 8'b0 || bus.pix_data !== 16'h0 || bus.err_code !== 3'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got valid %b rd %b data %h err %0d expected all 0",
               bus.pix_valid, bus.queue_rd_en, bus.pix_data, bus.err_code);
    end
    fifo_q.delete();
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start_test();
    put_frame(16'h0061);
    wait_drain("midreset", 200);
    check_int("midreset_pixels", acc_n, 8);
    check_int("midreset_done", done_cnt, 1);
    check_int("midreset_errors", perr_cnt, 0);
  endtask

  initial begin
    start_test();
    test_reset();
    test_full_frame();
    test_back_to_back_stall();
    test_short_row();
    test_mid_sof();
    test_unknown_ctrl();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
